// File: rtl/gate_chk_pkg.sv
// rtl/gate_chk_pkg.sv - shared types and expected truth tables for the gate checker
package gate_chk_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam int NUM_VECTORS = 4;
  localparam logic [1:0] LAST_IDX = 2'(NUM_VECTORS - 1);

  // Bit index of every table is {a,b}
  localparam logic [NUM_VECTORS-1:0] TT_AND  = 4'b1000;
  localparam logic [NUM_VECTORS-1:0] TT_NAND = 4'b0111;
  localparam logic [NUM_VECTORS-1:0] TT_OR   = 4'b1110;
  localparam logic [NUM_VECTORS-1:0] TT_NOR  = 4'b0001;
  localparam logic [NUM_VECTORS-1:0] TT_XOR  = 4'b0110;

endpackage

// File: rtl/gate_truth_checker_settle_timer.sv
// rtl/gate_truth_checker_settle_timer.sv - loadable 8-bit settle down-counter
module settle_timer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic       en,
  input  logic [7:0] load_val,
  output logic       zero
);

  logic [7:0] cnt;

  // Load wins over count; the counter parks at zero until reloaded
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= 8'd0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && (cnt != 8'd0)) begin
      cnt <= cnt - 8'd1;
    end
  end

  assign zero = (cnt == 8'd0);

endmodule

// File: rtl/gate_truth_checker.sv
// rtl/gate_truth_checker.sv - drives all four {a,b} vectors into a gate and checks its truth table
module gate_truth_checker
  import gate_chk_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] exp_tt,
  input  logic       gate_y,
  output logic       drv_a,
  output logic       drv_b,
  output logic       busy,
  output logic       done,
  output logic [3:0] truth_table,
  output logic [3:0] mismatch,
  output logic       pass
);

  localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES);

  state_t     state;
  logic [1:0] idx;
  logic [3:0] exp_q;
  logic [3:0] tt_next;
  logic       accept;
  logic       sample;
  logic       tmr_load;
  logic       tmr_zero;

  assign accept   = (state == IDLE) && start;
  assign sample   = (state == SETTLE) && tmr_zero;
  assign tmr_load = accept || (sample && (idx != LAST_IDX));

  settle_timer u_settle_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .en       (state == SETTLE),
    .load_val (SETTLE_LOAD),
    .zero     (tmr_zero)
  );

  // Table including the bit being sampled this cycle, so the last compare sees it
  always_comb begin
    tt_next      = truth_table;
    tt_next[idx] = gate_y;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      idx         <= 2'd0;
      exp_q       <= 4'd0;
      drv_a       <= 1'b0;
      drv_b       <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      truth_table <= 4'd0;
      mismatch    <= 4'd0;
      pass        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            exp_q          <= exp_tt;
            idx            <= 2'd0;
            {drv_a, drv_b} <= 2'b00;
            truth_table    <= 4'd0;
            mismatch       <= 4'd0;
            pass           <= 1'b0;
            busy           <= 1'b1;
            state          <= SETTLE;
          end
        end
        SETTLE: begin
          if (sample) begin
            truth_table <= tt_next;
            if (idx != LAST_IDX) begin
              idx            <= idx + 2'd1;
              {drv_a, drv_b} <= idx + 2'd1;
            end else begin
              mismatch <= tt_next ^ exp_q;
              pass     <= (tt_next == exp_q);
              busy     <= 1'b0;
              done     <= 1'b1;
              state    <= DONE;
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gate_truth_checker.sv
// tb/tb_gate_truth_checker.sv - directed checks of gate_truth_checker at S=2, S=0 and S=1
module tb_gate_truth_checker;

  typedef struct {
    int         d;
    int         kind;
    logic [3:0] exp_tt;
    logic [3:0] tt;
    logic [3:0] mm;
    logic       pass;
    int         lat;
  } vec_t;

  logic            clk;
  logic            rst_n;
  logic [2:0]      start_v;
  logic [2:0][3:0] exp_v;
  logic [2:0]      gate_y_v;
  logic [2:0]      drv_a_v;
  logic [2:0]      drv_b_v;
  logic [2:0]      busy_v;
  logic [2:0]      done_v;
  logic [2:0][3:0] tt_v;
  logic [2:0][3:0] mm_v;
  logic [2:0]      pass_v;
  int              kind_v [3];

  int n_checks;
  int n_errors;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // kinds: 0 AND, 1 NAND, 2 OR, 3 NOR, 4 XOR
  function automatic logic gate_eval(input int kind, input logic a, input logic b);
    case (kind)
      0:       return a & b;
      1:       return ~(a & b);
      2:       return a | b;
      3:       return ~(a | b);
      4:       return a ^ b;
      default: return 1'b0;
    endcase
  endfunction

  always_comb begin
    gate_y_v = '0;
    for (int i = 0; i < 3; i++) gate_y_v[i] = gate_eval(kind_v[i], drv_a_v[i], drv_b_v[i]);
  end

  gate_truth_checker #(.SETTLE_CYCLES(2)) u_s2 (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .exp_tt(exp_v[0]), .gate_y(gate_y_v[0]),
    .drv_a(drv_a_v[0]), .drv_b(drv_b_v[0]), .busy(busy_v[0]), .done(done_v[0]),
    .truth_table(tt_v[0]), .mismatch(mm_v[0]), .pass(pass_v[0])
  );

  gate_truth_checker #(.SETTLE_CYCLES(0)) u_s0 (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .exp_tt(exp_v[1]), .gate_y(gate_y_v[1]),
    .drv_a(drv_a_v[1]), .drv_b(drv_b_v[1]), .busy(busy_v[1]), .done(done_v[1]),
    .truth_table(tt_v[1]), .mismatch(mm_v[1]), .pass(pass_v[1])
  );

  gate_truth_checker #(.SETTLE_CYCLES(1)) u_s1 (
    .clk(clk), .rst_n(rst_n), .start(start_v[2]), .exp_tt(exp_v[2]), .gate_y(gate_y_v[2]),
    .drv_a(drv_a_v[2]), .drv_b(drv_b_v[2]), .busy(busy_v[2]), .done(done_v[2]),
    .truth_table(tt_v[2]), .mismatch(mm_v[2]), .pass(pass_v[2])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int cyc;
    kind_v[v.d] = v.kind;
    @(posedge clk); #1;
    start_v[v.d] = 1'b1;
    exp_v[v.d]   = v.exp_tt;
    @(posedge clk); #1;
    start_v[v.d] = 1'b0;
    check({tag, "_busy"}, 32'(busy_v[v.d]), 32'd1);
    cyc = 0;
    while (!done_v[v.d] && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    check({tag, "_latency"}, 32'(cyc), 32'(v.lat));
    check({tag, "_tt"}, 32'(tt_v[v.d]), 32'(v.tt));
    check({tag, "_mismatch"}, 32'(mm_v[v.d]), 32'(v.mm));
    check({tag, "_pass"}, 32'(pass_v[v.d]), 32'(v.pass));
    @(posedge clk); #1;
    check({tag, "_done_width"}, 32'(done_v[v.d]), 32'd0);
    check({tag, "_drv_hold"}, 32'({drv_a_v[v.d], drv_b_v[v.d]}), 32'd3);
  endtask

  vec_t vecs [6];
  int   dn;
  int   first;
  int   nd;
  int   pos [4];

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n    = 1'b0;
    start_v  = '0;
    exp_v    = '0;
    for (int i = 0; i < 3; i++) kind_v[i] = 0;

    vecs[0] = '{d: 0, kind: 0, exp_tt: 4'b1000, tt: 4'b1000, mm: 4'b0000, pass: 1'b1, lat: 12};
    vecs[1] = '{d: 0, kind: 0, exp_tt: 4'b1110, tt: 4'b1000, mm: 4'b0110, pass: 1'b0, lat: 12};
    vecs[2] = '{d: 1, kind: 1, exp_tt: 4'b0111, tt: 4'b0111, mm: 4'b0000, pass: 1'b1, lat: 4};
    vecs[3] = '{d: 1, kind: 4, exp_tt: 4'b0110, tt: 4'b0110, mm: 4'b0000, pass: 1'b1, lat: 4};
    vecs[4] = '{d: 2, kind: 3, exp_tt: 4'b1110, tt: 4'b0001, mm: 4'b1111, pass: 1'b0, lat: 8};
    vecs[5] = '{d: 0, kind: 2, exp_tt: 4'b0001, tt: 4'b1110, mm: 4'b1111, pass: 1'b0, lat: 12};

    #1;
    check("rst_drv_a", 32'(drv_a_v), 32'd0);
    check("rst_drv_b", 32'(drv_b_v), 32'd0);
    check("rst_busy", 32'(busy_v), 32'd0);
    check("rst_done", 32'(done_v), 32'd0);
    check("rst_pass", 32'(pass_v), 32'd0);
    check("rst_tt", 32'(tt_v), 32'd0);
    check("rst_mm", 32'(mm_v), 32'd0);

    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) run_vec(vecs[i], $sformatf("v%0d", i));

    // Driver stepping at S=2 with a stray start in the 5th cycle of the run
    kind_v[0] = 0;
    @(posedge clk); #1;
    start_v[0] = 1'b1;
    exp_v[0]   = 4'b1000;
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    dn    = 0;
    first = -1;
    for (int j = 0; j < 30; j++) begin
      if (j > 0) begin
        @(posedge clk); #1;
      end
      if (j == 4) start_v[0] = 1'b1;
      if (j == 5) start_v[0] = 1'b0;
      if (j < 12) check($sformatf("step_drv_%0d", j), 32'({drv_a_v[0], drv_b_v[0]}), 32'(j / 3));
      if (done_v[0]) begin
        dn++;
        if (first < 0) first = j;
      end
    end
    check("step_done_count", 32'(dn), 32'd1);
    check("step_done_cycle", 32'(first), 32'd12);
    check("step_pass", 32'(pass_v[0]), 32'd1);

    // Reset during vector 2 on the S=2 instance with an OR gate
    kind_v[0] = 2;
    @(posedge clk); #1;
    start_v[0] = 1'b1;
    exp_v[0]   = 4'b1110;
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("abort_pre_drv", 32'({drv_a_v[0], drv_b_v[0]}), 32'd2);
    check("abort_pre_tt", 32'(tt_v[0]), 32'b0010);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_drv", 32'({drv_a_v[0], drv_b_v[0]}), 32'd0);
    check("abort_busy", 32'(busy_v[0]), 32'd0);
    check("abort_tt", 32'(tt_v[0]), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    dn = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (done_v[0]) dn++;
    end
    check("abort_no_done", 32'(dn), 32'd0);
    run_vec('{d: 0, kind: 2, exp_tt: 4'b1110, tt: 4'b1110, mm: 4'b0000, pass: 1'b1, lat: 12}, "after_abort");

    // start held high for 40 cycles at S=1: done every 10 cycles
    kind_v[2] = 0;
    for (int i = 0; i < 4; i++) pos[i] = -1;
    nd = 0;
    @(posedge clk); #1;
    start_v[2] = 1'b1;
    exp_v[2]   = 4'b1000;
    for (int j = 0; j < 40; j++) begin
      @(posedge clk); #1;
      if (done_v[2]) begin
        if (nd < 4) pos[nd] = j;
        nd++;
        check($sformatf("held_tt_%0d", j), 32'(tt_v[2]), 32'b1000);
        check($sformatf("held_pass_%0d", j), 32'(pass_v[2]), 32'd1);
      end
    end
    start_v[2] = 1'b0;
    check("held_done_count", 32'(nd), 32'd4);
    for (int i = 0; i < 4; i++) check($sformatf("held_done_pos_%0d", i), 32'(pos[i]), 32'(8 + 10 * i));
    repeat (20) @(posedge clk);
    #1;
    check("held_idle_busy", 32'(busy_v[2]), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
